// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - March C- element tables, FSM encoding and run-length constant
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RDWR  = 3'd3,
        ST_RDCHK = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [2:0] ELEM_M0 = 3'd0;
    localparam logic [2:0] ELEM_M1 = 3'd1;
    localparam logic [2:0] ELEM_M2 = 3'd2;
    localparam logic [2:0] ELEM_M3 = 3'd3;
    localparam logic [2:0] ELEM_M4 = 3'd4;
    localparam logic [2:0] ELEM_M5 = 3'd5;

    // Bit e of each table describes march element e: descending sweep,
    // read expects the complement background, write stores the complement.
    localparam logic [7:0] ELEM_DOWN_TBL   = 8'b0001_1000;
    localparam logic [7:0] ELEM_RD_INV_TBL = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_INV_TBL = 8'b0000_1010;

    localparam int unsigned CYCLES_PER_ADDR = 11;

    function automatic logic elem_down(input logic [2:0] e);
        return ELEM_DOWN_TBL[e];
    endfunction

    function automatic logic elem_rd_inv(input logic [2:0] e);
        return ELEM_RD_INV_TBL[e];
    endfunction

    function automatic logic elem_wr_inv(input logic [2:0] e);
        return ELEM_WR_INV_TBL[e];
    endfunction

    function automatic int unsigned run_cycles(input int unsigned depth);
        return CYCLES_PER_ADDR * depth;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// rtl/sram_bist_addr_gen.sv - up/down address counter with load, step and terminal flag
module sram_bist_addr_gen #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              load_down_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == '1);

    // Stepping is suppressed at the terminal so the counter never wraps inside an element.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_down_i ? '1 : '0;
        end else if (step_i && !last_o) begin
            addr_d = down_i ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - March C- BIST initiator for a single-port synchronous RAM
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W = 5,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG0    = '0,
    parameter int                ERR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_enable,
    output logic              ram_r_w,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act
);

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_act_q, fail_act_d;
    logic [DATA_W-1:0] datain_q;

    logic              ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic [DATA_W-1:0] exp_rd, wr_bg;
    logic              cmp_en, mismatch;

    sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ag_load),
        .load_down_i(ag_load_down),
        .step_i     (ag_step),
        .down_i     (elem_down(elem_q)),
        .addr_o     (ag_addr),
        .last_o     (ag_last)
    );

    assign exp_rd   = elem_rd_inv(elem_q) ? ~BG0 : BG0;
    assign wr_bg    = elem_wr_inv(elem_q) ? ~BG0 : BG0;
    // Read data registered by the RAM on the RD edge is still held in RDWR/RDCHK.
    assign cmp_en   = (state_q == ST_RDWR) || (state_q == ST_RDCHK);
    assign mismatch = cmp_en && (ram_dataout != exp_rd);

    assign busy        = (state_q == ST_WR) || (state_q == ST_RD) ||
                         (state_q == ST_RDWR) || (state_q == ST_RDCHK);
    assign ram_address = ag_addr;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_addr   = fail_addr_q;
    assign fail_elem   = fail_elem_q;
    assign fail_exp    = fail_exp_q;
    assign fail_act    = fail_act_q;

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        ram_enable   = 1'b0;
        ram_r_w      = 1'b0;
        ram_datain   = datain_q;

        // A zero count means no mismatch yet this run, so the diagnostics are still free.
        if (mismatch) begin
            err_d = (err_q == '1) ? err_q : err_q + 1'b1;
            if (err_q == '0) begin
                fail_addr_d = ag_addr;
                fail_elem_d = elem_q;
                fail_exp_d  = exp_rd;
                fail_act_d  = ram_dataout;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WR;
                    elem_d      = ELEM_M0;
                    ag_load     = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                end
            end
            ST_WR: begin
                ram_enable = 1'b1;
                ram_r_w    = 1'b1;
                ram_datain = wr_bg;
                if (ag_last) begin
                    elem_d       = ELEM_M1;
                    ag_load      = 1'b1;
                    ag_load_down = elem_down(ELEM_M1);
                    state_d      = ST_RD;
                end else begin
                    ag_step = 1'b1;
                end
            end
            ST_RD: begin
                ram_enable = 1'b1;
                ram_datain = wr_bg;
                state_d    = (elem_q == ELEM_M5) ? ST_RDCHK : ST_RDWR;
            end
            ST_RDWR: begin
                ram_enable = 1'b1;
                ram_r_w    = 1'b1;
                ram_datain = wr_bg;
                state_d    = ST_RD;
                if (ag_last) begin
                    elem_d       = elem_q + 3'd1;
                    ag_load      = 1'b1;
                    ag_load_down = elem_down(elem_q + 3'd1);
                end else begin
                    ag_step = 1'b1;
                end
            end
            ST_RDCHK: begin
                if (ag_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    ag_step = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= ELEM_M0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            datain_q    <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            datain_q    <= ram_datain;
        end
    end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - scoreboard bench for sram_bist_ctrl with a faulty RAM model
module tb_sram_bist_ctrl;

    localparam int          ADDR_W     = 5;
    localparam int          DATA_W     = 8;
    localparam int          ERR_W      = 6;
    localparam int          DEPTH      = 32;
    localparam logic [7:0]  BG0        = 8'h00;
    localparam logic [7:0]  BG1        = 8'hFF;
    localparam int          RUN_CYCLES = 11 * DEPTH;

    localparam int F_NONE = 0, F_STUCK_BIT = 1, F_DOUT = 2, F_WDIS = 3;

    typedef struct {
        int         kind;
        int         addr;
        int         bitn;
        logic [7:0] val;
    } fault_t;

    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic [7:0] data;
    } op_t;

    typedef struct {
        logic       pass;
        logic [5:0] err;
        logic [4:0] faddr;
        logic [2:0] felem;
        logic [7:0] fexp;
        logic [7:0] fact;
        int         cycles;
    } res_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              ram_enable;
    logic              ram_r_w;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_datain;
    logic [DATA_W-1:0] ram_dataout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [DATA_W-1:0] fail_exp;
    logic [DATA_W-1:0] fail_act;

    sram_bist_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BG0(BG0), .ERR_W(ERR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ram_enable (ram_enable),
        .ram_r_w    (ram_r_w),
        .ram_address(ram_address),
        .ram_datain (ram_datain),
        .ram_dataout(ram_dataout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    fault_t     flt;
    logic [7:0] mem      [DEPTH];
    logic [7:0] init_mem [DEPTH];
    logic [7:0] dout_r;
    op_t        op_q  [$];
    res_t       exp_q [$];

    assign ram_dataout = dout_r;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fault_read(input fault_t f, input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        if (f.kind == F_STUCK_BIT && a == f.addr) r[f.bitn] = f.val[0];
        if (f.kind == F_DOUT) r = f.val;
        return r;
    endfunction

    function automatic logic write_ok(input fault_t f, input int a);
        return !(f.kind == F_WDIS && a == f.addr);
    endfunction

    function automatic fault_t mkf(input int k, input int a, input int b, input logic [7:0] v);
        fault_t f;
        f.kind = k; f.addr = a; f.bitn = b; f.val = v;
        return f;
    endfunction

    function automatic res_t mkr(input logic p, input int e, input int fa, input int fe,
                                 input logic [7:0] fx, input logic [7:0] fc);
        res_t r;
        r.pass = p; r.err = 6'(e); r.faddr = 5'(fa); r.felem = 3'(fe);
        r.fexp = fx; r.fact = fc; r.cycles = RUN_CYCLES;
        return r;
    endfunction

    // Behavioural RAM: registered read, dataout held on writes and idle cycles.
    initial begin
        dout_r = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_enable) begin
                if (ram_r_w) begin
                    if (write_ok(flt, int'(ram_address))) mem[ram_address] = ram_datain;
                end else begin
                    dout_r <= fault_read(flt, mem[ram_address], int'(ram_address));
                end
            end
        end
    end

    // Reference: March C- as a list of elements {direction, read bg, write bg}; -1 = no op.
    task automatic model_run(input fault_t f, output res_t r);
        int         rd_bg [6] = '{-1, 0, 1, 0, 1, 0};
        int         wr_bg [6] = '{ 0, 1, 0, 1, 0, -1};
        bit         dn    [6] = '{ 0, 0, 0, 1, 1, 0};
        logic [7:0] mm [DEPTH];
        logic [7:0] expv, got, wv;
        int         errs, a;
        op_t        o;
        mm   = init_mem;
        errs = 0;
        r    = mkr(1'b1, 0, 0, 0, 8'h00, 8'h00);
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = dn[e] ? DEPTH - 1 - k : k;
                if (rd_bg[e] >= 0) begin
                    expv = (rd_bg[e] == 1) ? BG1 : BG0;
                    o.rw = 1'b0; o.addr = 5'(a); o.data = 8'h00;
                    op_q.push_back(o);
                    got = fault_read(f, mm[a], a);
                    if (got != expv) begin
                        if (errs == 0) begin
                            r.faddr = 5'(a); r.felem = 3'(e); r.fexp = expv; r.fact = got;
                        end
                        errs++;
                    end
                end
                if (wr_bg[e] >= 0) begin
                    wv = (wr_bg[e] == 1) ? BG1 : BG0;
                    o.rw = 1'b1; o.addr = 5'(a); o.data = wv;
                    op_q.push_back(o);
                    if (write_ok(f, a)) mm[a] = wv;
                end
            end
        end
        r.err  = (errs > 63) ? 6'd63 : 6'(errs);
        r.pass = (errs == 0);
    endtask

    task automatic launch(input fault_t f, input bit use_plan, input res_t plan);
        res_t r;
        flt = f;
        mem = init_mem;
        model_run(f, r);
        exp_q.push_back(use_plan ? plan : r);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared_on_start", int'(done), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2 * RUN_CYCLES) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      int'(busy),        0);
        chk({tag, "_done"},      int'(done),        0);
        chk({tag, "_pass"},      int'(pass),        0);
        chk({tag, "_err"},       int'(err_count),   0);
        chk({tag, "_fail_addr"}, int'(fail_addr),   0);
        chk({tag, "_fail_elem"}, int'(fail_elem),   0);
        chk({tag, "_fail_exp"},  int'(fail_exp),    0);
        chk({tag, "_fail_act"},  int'(fail_act),    0);
        chk({tag, "_ram_en"},    int'(ram_enable),  0);
        chk({tag, "_ram_rw"},    int'(ram_r_w),     0);
        chk({tag, "_ram_addr"},  int'(ram_address), 0);
        chk({tag, "_ram_din"},   int'(ram_datain),  0);
    endtask

    task automatic rand_init();
        for (int i = 0; i < DEPTH; i++) init_mem[i] = 8'($urandom);
    endtask

    // Monitor: checks every RAM access against the expected op stream and the result at done.
    initial begin
        int   cyc;
        int   op_bad;
        logic done_p;
        op_t  o;
        res_t e;
        cyc = 0; op_bad = 0; done_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; op_bad = 0; done_p = 1'b0;
            end else begin
                if (busy) cyc++;
                if (ram_enable) begin
                    if (op_q.size() == 0) begin
                        op_bad++;
                    end else begin
                        o = op_q.pop_front();
                        if (o.rw != ram_r_w || o.addr != ram_address ||
                            (o.rw && o.data != ram_datain)) begin
                            if (op_bad == 0)
                                $display("ram op differs: rw=%0b addr=%0d din=%0h want rw=%0b addr=%0d din=%0h",
                                         ram_r_w, ram_address, ram_datain, o.rw, o.addr, o.data);
                            op_bad++;
                        end
                    end
                end
                if (done && !done_p) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_cycles", cyc,             e.cycles);
                        chk("busy_at_done", int'(busy),     0);
                        chk("pass",       int'(pass),      int'(e.pass));
                        chk("err_count",  int'(err_count), int'(e.err));
                        chk("fail_addr",  int'(fail_addr), int'(e.faddr));
                        chk("fail_elem",  int'(fail_elem), int'(e.felem));
                        chk("fail_exp",   int'(fail_exp),  int'(e.fexp));
                        chk("fail_act",   int'(fail_act),  int'(e.fact));
                        chk("ram_ops_bad", op_bad,         0);
                        chk("ram_ops_left", op_q.size(),   0);
                    end
                    cyc = 0; op_bad = 0;
                end
                done_p = done;
            end
        end
    end

    initial begin
        res_t   dummy;
        fault_t f;
        int     k;
        rst_n = 1'b0;
        start = 1'b0;
        flt   = mkf(F_NONE, 0, 0, 8'h00);
        dummy = mkr(1'b1, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) init_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("idle");

        rand_init();
        launch(mkf(F_NONE, 0, 0, 8'h00), 1'b1, mkr(1'b1, 0, 0, 0, 8'h00, 8'h00));
        wait_done();

        rand_init();
        launch(mkf(F_STUCK_BIT, 5, 0, 8'h01), 1'b1, mkr(1'b0, 3, 5, 1, 8'h00, 8'h01));
        wait_done();

        rand_init();
        launch(mkf(F_DOUT, 0, 0, 8'hFF), 1'b1, mkr(1'b0, 63, 0, 1, 8'h00, 8'hFF));
        wait_done();

        rand_init();
        launch(mkf(F_NONE, 0, 0, 8'h00), 1'b1, mkr(1'b1, 0, 0, 0, 8'h00, 8'h00));
        repeat (49) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_repulse", int'(busy), 1);
        wait_done();

        rand_init();
        launch(mkf(F_NONE, 0, 0, 8'h00), 1'b1, mkr(1'b1, 0, 0, 0, 8'h00, 8'h00));
        repeat (99) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        exp_q.delete();
        op_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rand_init();
        launch(mkf(F_NONE, 0, 0, 8'h00), 1'b1, mkr(1'b1, 0, 0, 0, 8'h00, 8'h00));
        wait_done();

        for (int i = 0; i < DEPTH; i++) init_mem[i] = 8'h00;
        launch(mkf(F_WDIS, 31, 0, 8'h00), 1'b1, mkr(1'b0, 2, 31, 2, 8'hFF, 8'h00));
        wait_done();

        for (int n = 0; n < 8; n++) begin
            rand_init();
            k = int'($urandom_range(0, 3));
            f = mkf(k, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)), 8'($urandom));
            launch(f, 1'b0, dummy);
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
